// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg
// Shared definitions for the FIFO port arbiter:
//   DW_DEF     - default data width of every data port
//   CNT_W_DEF  - default width of each grant statistics counter
//   idx_t      - requester index (two requesters per side)
package fifo_arb_pkg;

  localparam int DW_DEF    = 8;
  localparam int CNT_W_DEF = 8;

  typedef logic idx_t;

endpackage

// File: rtl/fifo_port_arbiter_rr_arb2.sv
// rr_arb2
// Two-way round-robin arbiter with its own last-granted pointer.
// Ports:
//   clk - clock, rising edge
//   rst - synchronous active-high reset
//   en  - arbitration enable (FIFO not full / not empty)
//   req - request vector, bit k from requester k
//   gnt - one-hot (or zero) grant vector, combinational
module rr_arb2
  import fifo_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  idx_t last_reg;

  // With both requesting, the one that did not win last time gets it;
  // a lone requester wins regardless of the pointer.
  always_comb begin
    gnt = 2'b00;
    if (!rst && en) begin
      if (req == 2'b11) gnt = last_reg ? 2'b01 : 2'b10;
      else              gnt = req;
    end
  end

  // Reset to 1 so requester 0 wins the first contention.
  always_ff @(posedge clk) begin
    if (rst)             last_reg <= 1'b1;
    else if (gnt != 2'b00) last_reg <= gnt[1];
  end

endmodule

// File: rtl/fifo_port_arbiter.sv
// fifo_port_arbiter
// Arbitrates two write requesters and two read requesters onto a single
// FIFO bank. Each side uses an independent round-robin arbiter; read data
// is registered and flagged with a one-cycle valid pulse.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   wreq0/1, wdata0/1        - write requests and data (held until granted)
//   wgnt0/1                  - write grants (combinational)
//   rreq0/1, rgnt0/1         - read requests and grants (combinational)
//   rdata0/1, rvalid0/1      - registered read data and valid pulse
//   fifo_we, fifo_wdata      - FIFO write strobe/data
//   fifo_full                - FIFO full, blocks write grants
//   fifo_re, fifo_rdata      - FIFO read strobe and head-of-queue data
//   fifo_empty               - FIFO empty, blocks read grants
//   wcnt0/1, rcnt0/1         - saturating grant counters, only when the
//                              FIFO_ARB_STATS_EN macro is defined
module fifo_port_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wreq0,
  input  logic             wreq1,
  input  logic [DW-1:0]    wdata0,
  input  logic [DW-1:0]    wdata1,
  output logic             wgnt0,
  output logic             wgnt1,
  input  logic             rreq0,
  input  logic             rreq1,
  output logic             rgnt0,
  output logic             rgnt1,
  output logic [DW-1:0]    rdata0,
  output logic [DW-1:0]    rdata1,
  output logic             rvalid0,
  output logic             rvalid1,
  output logic             fifo_we,
  output logic [DW-1:0]    fifo_wdata,
  input  logic             fifo_full,
  output logic             fifo_re,
  input  logic [DW-1:0]    fifo_rdata,
  input  logic             fifo_empty
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] wcnt0,
  output logic [CNT_W-1:0] wcnt1,
  output logic [CNT_W-1:0] rcnt0,
  output logic [CNT_W-1:0] rcnt1
`endif
);

  logic [1:0]    wgnt;
  logic [1:0]    rgnt;
  logic [DW-1:0] rdata0_reg;
  logic [DW-1:0] rdata1_reg;
  logic          rvalid0_reg;
  logic          rvalid1_reg;

  rr_arb2 u_warb (
    .clk (clk),
    .rst (rst),
    .en  (!fifo_full),
    .req ({wreq1, wreq0}),
    .gnt (wgnt)
  );

  rr_arb2 u_rarb (
    .clk (clk),
    .rst (rst),
    .en  (!fifo_empty),
    .req ({rreq1, rreq0}),
    .gnt (rgnt)
  );

  assign wgnt0 = wgnt[0];
  assign wgnt1 = wgnt[1];
  assign rgnt0 = rgnt[0];
  assign rgnt1 = rgnt[1];

  assign fifo_we = wgnt[0] | wgnt[1];
  assign fifo_re = rgnt[0] | rgnt[1];

  always_comb begin
    fifo_wdata = '0;
    if (wgnt[0])      fifo_wdata = wdata0;
    else if (wgnt[1]) fifo_wdata = wdata1;
  end

  // Head-of-queue data is captured on the grant edge; the other
  // requester's data register holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata0_reg  <= '0;
      rdata1_reg  <= '0;
      rvalid0_reg <= 1'b0;
      rvalid1_reg <= 1'b0;
    end else begin
      rvalid0_reg <= rgnt[0];
      rvalid1_reg <= rgnt[1];
      if (rgnt[0]) rdata0_reg <= fifo_rdata;
      if (rgnt[1]) rdata1_reg <= fifo_rdata;
    end
  end

  assign rdata0  = rdata0_reg;
  assign rdata1  = rdata1_reg;
  // Masking with rst drops a valid pulse that is pending when reset hits.
  assign rvalid0 = rvalid0_reg & ~rst;
  assign rvalid1 = rvalid1_reg & ~rst;

`ifdef FIFO_ARB_STATS_EN
  // Counter order: writer 0, writer 1, reader 0, reader 1.
  logic [3:0]       cnt_ev;
  logic [CNT_W-1:0] cnt_reg [4];

  assign cnt_ev = {rgnt[1], rgnt[0], wgnt[1], wgnt[0]};

  for (genvar gi = 0; gi < 4; gi++) begin : g_cnt
    always_ff @(posedge clk) begin
      if (rst)
        cnt_reg[gi] <= '0;
      else if (cnt_ev[gi] && (cnt_reg[gi] != {CNT_W{1'b1}}))
        cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
    end
  end

  assign wcnt0 = cnt_reg[0];
  assign wcnt1 = cnt_reg[1];
  assign rcnt0 = cnt_reg[2];
  assign rcnt1 = cnt_reg[3];
`endif

endmodule

// File: doc/fifo_port_arbiter.md
FIFO_PORT_ARBITER -- requirements
Module: fifo_port_arbiter

Interface
REQ-001 SHALL have parameter DW, default 8: data width of every data port.
REQ-002 SHALL have parameter CNT_W, default 8: width of each statistics counter.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have ports wreq0/wreq1, input, 1 each: write requester asserts request; wdata held stable until granted.
REQ-006 SHALL have ports wdata0/wdata1, input, DW each: requester write data.
REQ-007 SHALL have ports wgnt0/wgnt1, output, 1 each: write accepted this cycle (combinational).
REQ-008 SHALL have ports rreq0/rreq1, input, 1 each: read requester asserts request.
REQ-009 SHALL have ports rgnt0/rgnt1, output, 1 each: read accepted this cycle (combinational).
REQ-010 SHALL have ports rdata0/rdata1, output, DW each, and rvalid0/rvalid1, output, 1 each: registered read data and its one-cycle valid pulse.
REQ-011 SHALL have ports fifo_we, output, 1; fifo_wdata, output, DW; fifo_full, input, 1: FIFO bank write side.
REQ-012 SHALL have ports fifo_re, output, 1; fifo_rdata, input, DW (combinational head-of-queue data); fifo_empty, input, 1: FIFO bank read side.

Function
REQ-013 Write side SHALL grant at most one requester per cycle, only when fifo_full=0 and rst=0.
REQ-014 Write arbitration SHALL be round-robin: 1-bit pointer wlast records last granted writer; with both requesting, the writer other than wlast wins; single requester wins regardless of wlast.
REQ-015 fifo_we SHALL equal wgnt0|wgnt1; fifo_wdata SHALL equal the granted writer's wdata, else 0.
REQ-016 wlast SHALL update on the clock edge of a grant to the granted index; unchanged otherwise.
REQ-017 Read side SHALL apply REQ-013/014/016 identically with fifo_empty in place of fifo_full and pointer rlast; fifo_re SHALL equal rgnt0|rgnt1.
REQ-018 On a read grant to requester k in cycle N, rdatak SHALL capture fifo_rdata at edge ending N and rvalidk SHALL be 1 for exactly cycle N+1; rdata of the non-granted requester SHALL hold its previous value.
REQ-019 Write and read sides SHALL be independent; simultaneous write and read grants in one cycle SHALL both proceed.
REQ-020 A request with FIFO full (write) or empty (read) SHALL receive no grant and SHALL NOT change wlast/rlast; it is retried every cycle while held.
REQ-021 Back-to-back grants SHALL be sustainable: one grant per side per cycle while conditions hold, alternating between two continuous requesters.
REQ-022 Deasserting a request without grant SHALL be legal and leave no state behind.

Reset
REQ-023 While rst=1: all grants, fifo_we, fifo_re, rvalid0/1 SHALL be 0 combinationally.
REQ-024 At a clock edge with rst=1: wlast=1, rlast=1 (so requester 0 wins first contention), rdata0/1=0, rvalid0/1=0, counters=0.
REQ-025 Reset asserted mid-transfer SHALL discard a pending rvalid; no grant SHALL occur in the reset cycle.

Configuration
REQ-026 Macro FIFO_ARB_STATS_EN, when defined, SHALL add outputs wcnt0, wcnt1, rcnt0, rcnt1 (CNT_W each) counting grants per requester, saturating at all-ones, cleared by rst.
REQ-027 When FIFO_ARB_STATS_EN is undefined, those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-028 Shared package fifo_arb_pkg SHALL hold default DW/CNT_W constants and the requester-index type (1-bit).
REQ-029 One sub-module rr_arb2 (2-way round-robin grant plus pointer register, enable input for full/empty) SHALL be instantiated twice, once per side.

Verification
REQ-030 Reset: rst=1 two cycles with all requests high -> all grants/fifo_we/fifo_re/rvalid 0; rdata0/1=0.
REQ-031 Contention: wreq0=wreq1=1, wdata0=8'hA5, wdata1=8'h5A, fifo_full=0 for 4 cycles -> fifo_wdata A5,5A,A5,5A; wgnt alternates starting with 0.
REQ-032 Full blocking: fifo_full=1, wreq1=1 for 3 cycles -> no wgnt1, fifo_we=0; fifo_full drops -> wgnt1 same cycle.
REQ-033 Read latency: fifo_empty=0, fifo_rdata=8'h3C, rreq1=1 one cycle N -> rgnt1=1, fifo_re=1 in N; rvalid1=1, rdata1=8'h3C in N+1 only.
REQ-034 Simultaneous: wreq0 and rreq0 both high, fifo not full/empty -> wgnt0 and rgnt0 both 1 same cycle.
REQ-035 Stats (FIFO_ARB_STATS_EN, CNT_W=2): 5 grants to writer 0 -> wcnt0=3 (saturated), others 0.
